// File: rtl/full_subtractor_reg_pkg.sv
// Shared constants for the registered full subtractor.
// Holds the default operand width used by the top level.
package full_subtractor_reg_pkg;

  localparam int FS_DEFAULT_WIDTH = 1;

endpackage

// File: rtl/full_subtractor_reg_fs_cell.sv
// One-bit combinational full subtractor cell.
// Ports: a, b, bin in; d (difference), bout (borrow) out.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic axb;

  assign axb  = a ^ b;
  assign d    = axb ^ bin;
  assign bout = (~a & b) | (~axb & bin);

endmodule

// File: rtl/full_subtractor_reg.sv
// Registered a - b - Bin with borrow-out; 1-cycle latency.
// Ports: clk, rst_n, in_valid, a, b, Bin in; D, Bout, out_valid out.
module full_subtractor_reg
  import full_subtractor_reg_pkg::*;
#(
  parameter int WIDTH = FS_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             out_valid
);

  logic [WIDTH:0]   br;
  logic [WIDTH-1:0] d_c;

  assign br[0] = Bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fs_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (br[i]),
      .d    (d_c[i]),
      .bout (br[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      D         <= '0;
      Bout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        D    <= d_c;
        Bout <= br[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_full_subtractor_reg.sv
// Self-checking bench for full_subtractor_reg.
// Exercises WIDTH=1 and WIDTH=8 instances.
module tb_full_subtractor_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       iv1 = 1'b0, a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
  logic       d1, bo1, ov1;
  logic       iv8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [7:0] d8;
  logic       bo8, ov8;

  int n_cmp = 0;
  int n_fail = 0;

  logic [8:0] q1[$];
  logic [8:0] q8[$];
  logic [8:0] last1 = '0;
  logic [8:0] last8 = '0;

  always #5 clk = ~clk;

  full_subtractor_reg #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1),
    .a(a1), .b(b1), .Bin(bin1),
    .D(d1), .Bout(bo1), .out_valid(ov1)
  );

  full_subtractor_reg #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8),
    .a(a8), .b(b8), .Bin(bin8),
    .D(d8), .Bout(bo8), .out_valid(ov8)
  );

  // Arithmetic reference: {bout, d} at full precision.
  function automatic logic [8:0] model(
    input int w, input logic [7:0] a, input logic [7:0] b,
    input logic bin
  );
    int diff;
    int mask;
    logic [7:0] d;
    diff = int'(a) - int'(b) - int'(bin);
    mask = (1 << w) - 1;
    d = 8'(diff & mask);
    return {(int'(a) < int'(b) + int'(bin)), d};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step1(input logic va, input logic vb,
                       input logic vbin, input logic vv,
                       input string tag);
    a1 = va; b1 = vb; bin1 = vbin; iv1 = vv;
    if (vv) q1.push_back(model(1, {7'd0, va}, {7'd0, vb}, vbin));
    @(posedge clk); #1;
    chk({tag, ".ov"}, {7'd0, ov1}, {7'd0, vv});
    if (vv) begin
      if (q1.size() == 0) chk({tag, ".q"}, 8'd0, 8'd1);
      else last1 = q1.pop_front();
    end
    chk({tag, ".D"}, {7'd0, d1}, {7'd0, last1[0]});
    chk({tag, ".Bout"}, {7'd0, bo1}, {7'd0, last1[8]});
  endtask

  task automatic step8(input logic [7:0] va, input logic [7:0] vb,
                       input logic vbin, input logic vv,
                       input string tag);
    a8 = va; b8 = vb; bin8 = vbin; iv8 = vv;
    if (vv) q8.push_back(model(8, va, vb, vbin));
    @(posedge clk); #1;
    chk({tag, ".ov"}, {7'd0, ov8}, {7'd0, vv});
    if (vv) begin
      if (q8.size() == 0) chk({tag, ".q"}, 8'd0, 8'd1);
      else last8 = q8.pop_front();
    end
    chk({tag, ".D"}, d8, last8[7:0]);
    chk({tag, ".Bout"}, {7'd0, bo8}, {7'd0, last8[8]});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".D1"}, {7'd0, d1}, 8'd0);
    chk({tag, ".B1"}, {7'd0, bo1}, 8'd0);
    chk({tag, ".V1"}, {7'd0, ov1}, 8'd0);
    chk({tag, ".D8"}, d8, 8'd0);
    chk({tag, ".B8"}, {7'd0, bo8}, 8'd0);
    chk({tag, ".V8"}, {7'd0, ov8}, 8'd0);
  endtask

  initial begin
    // Reset with live, valid inputs driven.
    #1 rst_n = 1'b0;
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; bin1 = 1'b1;
    iv8 = 1'b1; a8 = 8'h01; b8 = 8'h02; bin8 = 1'b1;
    #1 chk_zero("rst_now");
    repeat (3) begin
      @(posedge clk); #1;
      chk_zero("rst_hold");
    end
    iv1 = 1'b0; iv8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed WIDTH=1 sequence.
    step1(0, 0, 0, 1, "dir000");
    step1(0, 1, 0, 1, "dir010");
    step1(1, 0, 0, 1, "dir100");
    step1(1, 1, 0, 1, "dir110");
    step1(0, 1, 1, 1, "dir011");

    // Exhaustive WIDTH=1, back to back.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      step1(v[2], v[1], v[0], 1, $sformatf("exh%0d", i));
    end
    // Truth-table spot checks against literal values.
    step1(0, 0, 1, 1, "tt001");
    chk("tt001.litD", {7'd0, d1}, 8'd1);
    chk("tt001.litB", {7'd0, bo1}, 8'd1);
    step1(1, 0, 1, 1, "tt101");
    chk("tt101.litD", {7'd0, d1}, 8'd0);
    chk("tt101.litB", {7'd0, bo1}, 8'd0);

    // Hold when in_valid is low.
    step1(1, 0, 0, 1, "hold_cap");
    step1(0, 1, 1, 0, "hold_idle");
    chk("hold.litD", {7'd0, d1}, 8'd1);
    chk("hold.litB", {7'd0, bo1}, 8'd0);
    step1(1, 1, 1, 0, "hold_idle2");

    // Mid-stream asynchronous reset.
    step1(1, 0, 0, 1, "ms_a");
    a1 = 1'b0; b1 = 1'b1; bin1 = 1'b0; iv1 = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_zero("ms_rst");
    q1.delete(); last1 = '0;
    @(posedge clk); #1;
    chk_zero("ms_edge");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    step1(1, 1, 1, 1, "ms_post");
    chk("ms_post.litD", {7'd0, d1}, 8'd1);
    chk("ms_post.litB", {7'd0, bo1}, 8'd1);
    step1(0, 0, 0, 0, "ms_idle");

    // WIDTH=8.
    step8(8'h05, 8'h07, 1, 1, "w8_a");
    chk("w8_a.litD", d8, 8'hFD);
    step8(8'hFF, 8'h00, 0, 1, "w8_b");
    chk("w8_b.litD", d8, 8'hFF);
    step8(8'h80, 8'h7F, 1, 1, "w8_c");
    step8(8'h00, 8'hFF, 1, 1, "w8_d");
    step8(8'h3C, 8'h3C, 0, 1, "w8_e");
    step8(8'h12, 8'h34, 0, 0, "w8_idle");
    for (int k = 0; k < 16; k++)
      step8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $sformatf("w8_r%0d", k));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/full_subtractor_reg.md
# full_subtractor_reg

Registered full subtractor: computes `a − b − Bin` with borrow-out and presents the difference and borrow on registered outputs one clock after a valid input. It is a datapath leaf used wherever a synchronous borrow-chain stage is needed. Instances can be cascaded through `Bout` → `Bin`. The default `WIDTH` = 1 gives the classic one-bit full subtractor; wider instances ripple through one-bit cells.

## Interface
- `WIDTH`, default 1, operand and difference width in bits (≥ 1).
- `clk`: input, 1 bit, sole clock; all state updates on the rising edge.
- `rst_n`: input, 1 bit, asynchronous active-low reset.
- `in_valid`: input, 1 bit, qualifies `a`, `b` and `Bin` this cycle.
- `a`: input, `WIDTH` bits, minuend (unsigned).
- `b`: input, `WIDTH` bits, subtrahend (unsigned).
- `Bin`: input, 1 bit, borrow-in.
- `D`: output, `WIDTH` bits, registered difference.
- `Bout`: output, 1 bit, registered borrow-out.
- `out_valid`: output, 1 bit, high for one cycle per accepted input.

## Operation
- Per-bit cell: `d_i = a_i ^ b_i ^ br_i` and `br_{i+1} = (~a_i & b_i) | (~(a_i ^ b_i) & br_i)`.
  - `br_0 = Bin`.
  - `Bout = br_WIDTH`.
- Arithmetic result: `D = (a − b − Bin) mod 2^WIDTH`. `Bout = 1` if and only if `a < b + Bin` (unsigned, evaluated at full precision).
- One-bit truth table:

  | `a` `b` `Bin` | `D` | `Bout` |
  |---|---|---|
  | 000 | 0 | 0 |
  | 001 | 1 | 1 |
  | 010 | 1 | 1 |
  | 011 | 0 | 1 |
  | 100 | 1 | 0 |
  | 101 | 0 | 0 |
  | 110 | 0 | 0 |
  | 111 | 1 | 1 |

- `in_valid` = 1: capture result into `D` and `Bout`, and set `out_valid` = 1 at the next edge.
- `in_valid` = 0: `D` and `Bout` hold their last value, and `out_valid` = 0 at the next edge.
- No back-pressure: a result is produced every cycle `in_valid` is high, and the downstream stage must accept it.
- No X propagation from unqualified inputs: inputs are ignored when `in_valid` = 0.

## Timing
- Latency is exactly 1 clock from the `in_valid` edge to `out_valid`, `D` and `Bout`. Throughput is 1 result per clock.
- Reset assertion (asynchronous, any time, including mid-stream): `D` = 0, `Bout` = 0 and `out_valid` = 0 immediately, with no clock needed.
- While `rst_n` = 0, inputs are ignored.
- Reset release: the first capture happens on the first rising edge with `rst_n` = 1 and `in_valid` = 1.
- Back-to-back valid inputs give back-to-back `out_valid` pulses, each carrying the matching result.
- The combinational path from the inputs through the `WIDTH`-bit ripple to the capture registers is the critical path. There is no internal pipelining; `WIDTH` is sized accordingly.

## Structure
- Shared package: none required. `WIDTH` stays a module parameter, and there are no typedefs or enums (no FSM).
- One natural sub-module, `fs_cell`: a purely combinational one-bit full subtractor.
  - Inputs `a`, `b`, `bin`; outputs `d`, `bout`.
  - Instantiated `WIDTH` times in a generate loop, with `bout` of cell i driving `bin` of cell i+1.
- Top level: the generate chain, the input qualification, and three registers (`D`, `Bout`, `out_valid`) with async active-low reset.

## Test plan
- Reset: assert `rst_n` = 0 with `in_valid` = 1, `a` = 1, `b` = 1, `Bin` = 1 → `D` = 0, `Bout` = 0 and `out_valid` = 0 immediately and throughout reset.
- `WIDTH` = 1 directed sequence, one valid per clock, each checked 1 cycle later:
  - (0,0,0) → `D` 0, `Bout` 0
  - (0,1,0) → `D` 1, `Bout` 1
  - (1,0,0) → `D` 1, `Bout` 0
  - (1,1,0) → `D` 0, `Bout` 0
  - (0,1,1) → `D` 0, `Bout` 1
- `WIDTH` = 1 exhaustive: all 8 `{a,b,Bin}` combinations → results match the truth table above, and `out_valid` pulses for each.
- Hold: apply (1,0,0) with valid, then `in_valid` = 0 with (0,1,1) on the inputs → `D` stays 1, `Bout` stays 0, `out_valid` drops to 0.
- Mid-stream reset: pulse `rst_n` low between clock edges during back-to-back valids → outputs clear asynchronously. After release, the next valid (1,1,1) → `D` 1, `Bout` 1.
- `WIDTH` = 8:
  - `a` = 0x05, `b` = 0x07, `Bin` = 1 → `D` = 0xFD, `Bout` = 1.
  - `a` = 0xFF, `b` = 0x00, `Bin` = 0 → `D` = 0xFF, `Bout` = 0.
